// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a CPU (read/write) and a GPU (read-only) share
// one synchronous single-port RAM with a fixed read latency of one cycle.
// The CPU has priority, but after MAXHOLD consecutive CPU grants with the GPU
// waiting, the GPU gets the next slot so it cannot starve.
module mem_arbiter #(
    parameter int N       = 32,
    parameter int AW      = 32,
    parameter int MAXHOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpuReq,
    input  logic          cpuWR,
    input  logic [AW-1:0] cpuAddress,
    input  logic [N-1:0]  cpuData,
    output logic          cpuGnt,
    output logic          cpuValid,
    output logic [N-1:0]  cpuOut,
    input  logic          gpuReq,
    input  logic [AW-1:0] gpuAddress,
    output logic          gpuGnt,
    output logic          gpuValid,
    output logic [N-1:0]  gpuOut,
    output logic          memEn,
    output logic [AW-1:0] memAddress,
    output logic [N-1:0]  memData,
    input  logic [N-1:0]  memQ
);

    localparam int HW = $clog2(MAXHOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);

    // Owner of the previous cycle; selects which requester sees the RAM output.
    typedef enum logic [1:0] {
        IDLE,
        CPU_OWN,
        GPU_OWN
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          cpu_rd_q;   // previous CPU grant was a read

    // Arbitration, owner tracking and starvation counter update.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves
        // a signal unassigned and no latch is inferred.
        cpuGnt    = 1'b0;
        gpuGnt    = 1'b0;
        state_nxt = IDLE;
        hold_nxt  = hold_cnt;

        // Grants are suppressed during reset so the RAM sees no access.
        if (!rst) begin
            if (cpuReq && (!gpuReq || hold_cnt < HOLD_MAX)) begin
                cpuGnt = 1'b1;
            end else if (gpuReq) begin
                gpuGnt = 1'b1;
            end
        end

        if (cpuGnt) begin
            state_nxt = CPU_OWN;
        end else if (gpuGnt) begin
            state_nxt = GPU_OWN;
        end

        // The counter only measures how long the GPU has been kept waiting.
        if (gpuGnt || !gpuReq) begin
            hold_nxt = '0;
        end else if (cpuGnt && hold_cnt < HOLD_MAX) begin
            hold_nxt = hold_cnt + HW'(1);
        end
    end

    // RAM request mux: the granted requester drives the address; idle cycles are all-zero.
    always_comb begin
        memEn      = cpuGnt & cpuWR;
        memAddress = '0;
        memData    = '0;
        if (cpuGnt) begin
            memAddress = cpuAddress;
            memData    = cpuData;
        end else if (gpuGnt) begin
            memAddress = gpuAddress;
            memData    = cpuData;
        end
    end

    // State register; async reset discards any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            cpu_rd_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            cpu_rd_q <= cpuGnt & ~cpuWR;
        end
    end

    // Read completion: RAM data is steered to whoever owned the previous cycle.
    always_comb begin
        cpuValid = (state == CPU_OWN) && cpu_rd_q;
        gpuValid = (state == GPU_OWN);
        cpuOut   = cpuValid ? memQ : '0;
        gpuOut   = gpuValid ? memQ : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a behavioural 256-word
// synchronous RAM (one-cycle read latency, reloaded with a known pattern on reset).
module tb_mem_arbiter;

    localparam int N  = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpuReq = 1'b0, cpuWR = 1'b0, gpuReq = 1'b0;
    logic [AW-1:0] cpuAddress = '0, gpuAddress = '0;
    logic [N-1:0]  cpuData = '0;
    logic          cpuGnt, cpuValid, gpuGnt, gpuValid, memEn;
    logic [N-1:0]  cpuOut, gpuOut, memData, memQ;
    logic [AW-1:0] memAddress;

    logic [N-1:0]  ram [256];

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.N(N), .AW(AW), .MAXHOLD(4)) dut (
        .clk(clk), .rst(rst),
        .cpuReq(cpuReq), .cpuWR(cpuWR), .cpuAddress(cpuAddress), .cpuData(cpuData),
        .cpuGnt(cpuGnt), .cpuValid(cpuValid), .cpuOut(cpuOut),
        .gpuReq(gpuReq), .gpuAddress(gpuAddress),
        .gpuGnt(gpuGnt), .gpuValid(gpuValid), .gpuOut(gpuOut),
        .memEn(memEn), .memAddress(memAddress), .memData(memData), .memQ(memQ)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: reloaded with 0x1000_0000 + index while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h1000_0000 + 32'(i);
        end else if (memEn) begin
            ram[memAddress[7:0]] <= memData;
        end
        memQ <= ram[memAddress[7:0]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, creq, cwr;
        logic [31:0] caddr, cdata;
        logic        greq;
        logic [31:0] gaddr;
        logic        e_cgnt, e_ggnt, e_en;
        logic [31:0] e_addr, e_data;
        logic        e_cv;
        logic [31:0] e_cout;
        logic        e_gv;
        logic [31:0] e_gout;
    } vec_t;

    function automatic vec_t mk(
        logic r, logic cq, logic cw, logic [31:0] ca, logic [31:0] cd, logic gq, logic [31:0] ga,
        logic ecg, logic egg, logic een, logic [31:0] ea, logic [31:0] ed,
        logic ecv, logic [31:0] eco, logic egv, logic [31:0] ego);
        vec_t v;
        v.rst = r; v.creq = cq; v.cwr = cw; v.caddr = ca; v.cdata = cd; v.greq = gq; v.gaddr = ga;
        v.e_cgnt = ecg; v.e_ggnt = egg; v.e_en = een; v.e_addr = ea; v.e_data = ed;
        v.e_cv = ecv; v.e_cout = eco; v.e_gv = egv; v.e_gout = ego;
        return v;
    endfunction

    task automatic drive(input logic r, input logic cq, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic gq, input logic [31:0] ga);
        @(negedge clk);
        rst = r; cpuReq = cq; cpuWR = cw; cpuAddress = ca; cpuData = cd;
        gpuReq = gq; gpuAddress = ga;
        #2;
    endtask

    localparam int NV = 19;
    vec_t vecs [NV];

    int  hold_m;
    logic exp_c, exp_g, prev_crd, prev_g;
    logic [7:0] greq_pat, ggnt_pat;

    initial begin
        //            rst cq cw caddr   cdata          gq gaddr | cg gg en addr   data          cv cout           gv gout
        vecs[0]  = mk(1, 1, 1, 32'h10, 32'hDEADBEEF, 1, 32'h3, 0, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(1, 0, 0, 32'h0,  32'h0,        0, 32'h0, 0, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 32'h0);
        vecs[2]  = mk(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
        vecs[3]  = mk(0, 1, 0, 32'h10, 32'h0,        0, 32'h0, 1, 0, 0, 32'h10, 32'h0,        0, 32'h0,        0, 32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,  32'h0,        0, 32'h0, 0, 0, 0, 32'h0,  32'h0,        1, 32'hDEADBEEF, 0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 32'h0,  32'h0,        0, 32'h0, 0, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 32'h0);
        vecs[6]  = mk(0, 0, 0, 32'h0,  32'h0,        1, 32'h1, 0, 1, 0, 32'h1,  32'h0,        0, 32'h0,        0, 32'h0);
        vecs[7]  = mk(0, 0, 0, 32'h0,  32'h0,        1, 32'h2, 0, 1, 0, 32'h2,  32'h0,        0, 32'h0,        1, 32'h10000001);
        vecs[8]  = mk(0, 0, 0, 32'h0,  32'h0,        0, 32'h0, 0, 0, 0, 32'h0,  32'h0,        0, 32'h0,        1, 32'h10000002);
        vecs[9]  = mk(0, 1, 1, 32'h20, 32'h11112222, 1, 32'h5, 1, 0, 1, 32'h20, 32'h11112222, 0, 32'h0,        0, 32'h0);
        vecs[10] = mk(0, 1, 1, 32'h20, 32'h33334444, 1, 32'h5, 1, 0, 1, 32'h20, 32'h33334444, 0, 32'h0,        0, 32'h0);
        vecs[11] = mk(0, 1, 1, 32'h20, 32'h55556666, 1, 32'h5, 1, 0, 1, 32'h20, 32'h55556666, 0, 32'h0,        0, 32'h0);
        vecs[12] = mk(0, 0, 0, 32'h0,  32'h0,        0, 32'h0, 0, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 32'h0);
        vecs[13] = mk(0, 1, 0, 32'h20, 32'h0,        0, 32'h0, 1, 0, 0, 32'h20, 32'h0,        0, 32'h0,        0, 32'h0);
        vecs[14] = mk(0, 0, 0, 32'h0,  32'h0,        0, 32'h0, 0, 0, 0, 32'h0,  32'h0,        1, 32'h55556666, 0, 32'h0);
        vecs[15] = mk(0, 0, 0, 32'h0,  32'h0,        1, 32'h4, 0, 1, 0, 32'h4,  32'h0,        0, 32'h0,        0, 32'h0);
        vecs[16] = mk(1, 1, 0, 32'h30, 32'h0,        1, 32'h4, 0, 0, 0, 32'h0,  32'h0,        0, 32'h0,        0, 32'h0);
        vecs[17] = mk(0, 0, 0, 32'h0,  32'h0,        1, 32'h6, 0, 1, 0, 32'h6,  32'h0,        0, 32'h0,        0, 32'h0);
        vecs[18] = mk(0, 0, 0, 32'h0,  32'h0,        0, 32'h0, 0, 0, 0, 32'h0,  32'h0,        0, 32'h0,        1, 32'h10000006);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].creq, vecs[i].cwr, vecs[i].caddr, vecs[i].cdata,
                  vecs[i].greq, vecs[i].gaddr);
            check($sformatf("v%0d cpuGnt", i),     32'(cpuGnt),   32'(vecs[i].e_cgnt));
            check($sformatf("v%0d gpuGnt", i),     32'(gpuGnt),   32'(vecs[i].e_ggnt));
            check($sformatf("v%0d memEn", i),      32'(memEn),    32'(vecs[i].e_en));
            check($sformatf("v%0d memAddress", i), memAddress,    vecs[i].e_addr);
            check($sformatf("v%0d memData", i),    memData,       vecs[i].e_data);
            check($sformatf("v%0d cpuValid", i),   32'(cpuValid), 32'(vecs[i].e_cv));
            check($sformatf("v%0d cpuOut", i),     cpuOut,        vecs[i].e_cout);
            check($sformatf("v%0d gpuValid", i),   32'(gpuValid), 32'(vecs[i].e_gv));
            check($sformatf("v%0d gpuOut", i),     gpuOut,        vecs[i].e_gout);
        end

        // GPU stream: 8 back-to-back reads of addresses 0..7, data one cycle later.
        for (int c = 0; c < 9; c++) begin
            drive(0, 0, 0, 0, 0, (c < 8), 32'(c));
            check($sformatf("stream%0d gpuGnt", c),   32'(gpuGnt),   32'(c < 8));
            check($sformatf("stream%0d gpuValid", c), 32'(gpuValid), 32'(c > 0));
            check($sformatf("stream%0d gpuOut", c),   gpuOut,
                  (c > 0) ? 32'h1000_0000 + 32'(c - 1) : 32'h0);
        end

        // Starvation cap: both requesting, CPU reads -> C,C,C,C,G repeating.
        for (int c = 0; c < 11; c++) begin
            drive(0, (c < 10), 0, 32'h40 + 32'(c), 0, (c < 10), 32'h80 + 32'(c));
            exp_g = (c < 10) && (c % 5 == 4);
            exp_c = (c < 10) && !exp_g;
            check($sformatf("starve%0d cpuGnt", c), 32'(cpuGnt), 32'(exp_c));
            check($sformatf("starve%0d gpuGnt", c), 32'(gpuGnt), 32'(exp_g));
            if (c > 0) begin
                check($sformatf("starve%0d cpuValid", c), 32'(cpuValid), 32'((c - 1) % 5 != 4));
                check($sformatf("starve%0d gpuValid", c), 32'(gpuValid), 32'((c - 1) % 5 == 4));
                check($sformatf("starve%0d data", c), cpuOut | gpuOut,
                      ((c - 1) % 5 == 4) ? 32'h1000_0080 + 32'(c - 1) : 32'h1000_0040 + 32'(c - 1));
            end
        end

        // A cycle with gpuReq low must clear the hold count mid-run.
        greq_pat = 8'b1111_1011;
        ggnt_pat = 8'b1000_0000;
        for (int c = 0; c < 8; c++) begin
            drive(0, 1, 0, 32'h50, 0, greq_pat[c], 32'h90);
            check($sformatf("holdclr%0d gpuGnt", c), 32'(gpuGnt), 32'(ggnt_pat[c]));
            check($sformatf("holdclr%0d cpuGnt", c), 32'(cpuGnt), 32'(!ggnt_pat[c]));
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // Random traffic against an independent arbitration model.
        drive(0, 0, 0, 0, 0, 0, 0);
        hold_m = 0; prev_crd = 1'b0; prev_g = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  $urandom, 1'($urandom_range(0, 1)), $urandom);
            exp_c = cpuReq && (!gpuReq || hold_m < 4);
            exp_g = gpuReq && !exp_c;
            assert (!(cpuGnt && gpuGnt)) else $error("both grants high");
            check("rnd excl", 32'(cpuGnt & gpuGnt), 32'h0);
            check("rnd cpuGnt", 32'(cpuGnt), 32'(exp_c));
            check("rnd gpuGnt", 32'(gpuGnt), 32'(exp_g));
            check("rnd cpuValid", 32'(cpuValid), 32'(prev_crd));
            check("rnd gpuValid", 32'(gpuValid), 32'(prev_g));
            check("rnd cpuOut", cpuOut, prev_crd ? memQ : 32'h0);
            check("rnd gpuOut", gpuOut, prev_g ? memQ : 32'h0);
            check("rnd memEn", 32'(memEn), 32'(exp_c && cpuWR));
            if (exp_g || !gpuReq)  hold_m = 0;
            else if (exp_c && hold_m < 4) hold_m++;
            prev_crd = exp_c && !cpuWR;
            prev_g   = exp_g;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 32, data width.
REQ-002 The module SHALL have parameter AW, default 32, address width.
REQ-003 The module SHALL have parameter MAXHOLD, default 4: consecutive CPU grants allowed while the GPU waits.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port cpuReq  input  1  CPU access request.
REQ-007 Port cpuWR  input  1  CPU access type: 1 = write, 0 = read.
REQ-008 Port cpuAddress  input  AW  CPU address.
REQ-009 Port cpuData  input  N  CPU write data.
REQ-010 Port cpuGnt  output  1  CPU access accepted this cycle.
REQ-011 Port cpuValid  output  1  CPU read data valid.
REQ-012 Port cpuOut  output  N  CPU read data.
REQ-013 Port gpuReq  input  1  GPU read request.
REQ-014 Port gpuAddress  input  AW  GPU address.
REQ-015 Port gpuGnt  output  1  GPU access accepted this cycle.
REQ-016 Port gpuValid  output  1  GPU read data valid.
REQ-017 Port gpuOut  output  N  GPU read data.
REQ-018 Port memEn  output  1  RAM write enable.
REQ-019 Port memAddress  output  AW  RAM address.
REQ-020 Port memData  output  N  RAM write data.
REQ-021 Port memQ  input  N  RAM read data, synchronous, available one cycle after the address is presented.

Function
REQ-022 At most one of cpuGnt and gpuGnt SHALL be high in any cycle; both are combinational from the requests and registered state.
REQ-023 State register values: IDLE, CPU_OWN, GPU_OWN. The state SHALL record the owner of the previous cycle: no grant -> IDLE, cpuGnt -> CPU_OWN, gpuGnt -> GPU_OWN.
REQ-024 Arbitration:
  - only cpuReq high -> grant CPU.
  - only gpuReq high -> grant GPU.
  - both high and holdCnt < MAXHOLD -> grant CPU.
  - both high and holdCnt == MAXHOLD -> grant GPU.
REQ-025 holdCnt:
  - width clog2(MAXHOLD+1).
  - +1 on a CPU grant while gpuReq is high; saturates at MAXHOLD.
  - cleared to 0 on any GPU grant or any cycle with gpuReq low.
REQ-026 Granted cycle:
  - memAddress = granted requester's address.
  - memData = cpuData.
  - memEn = cpuGnt & cpuWR; a GPU grant never writes.
REQ-027 Cycle with no grant: memEn=0, memAddress=0, memData=0.
REQ-028 Read completion:
  - cpuValid SHALL pulse exactly one cycle after a CPU read grant.
  - gpuValid SHALL pulse exactly one cycle after a GPU grant.
  - CPU writes SHALL produce no valid pulse.
REQ-029 Read data:
  - cpuOut = memQ while cpuValid = 1, else 0.
  - gpuOut = memQ while gpuValid = 1, else 0.
REQ-030 Back-to-back grants to either requester SHALL be sustained at one access per cycle; read latency is fixed at 1.
REQ-031 A requester not granted SHALL keep its request and address stable; the arbiter does not queue requests.
REQ-032 Read-after-write to the same address: the CPU write SHALL complete in cycle t; a read granted in t+1 returns the written data in t+2.

Reset
REQ-033 While rst=1 the module SHALL hold:
  - state = IDLE, holdCnt = 0.
  - cpuGnt = gpuGnt = 0, cpuValid = gpuValid = 0.
  - cpuOut = gpuOut = 0, memEn = 0, memAddress = 0, memData = 0.
REQ-034 Reset asserted mid-access SHALL discard any pending valid pulse; the first grant can occur in the first cycle after rst deasserts.

Verification
REQ-035 CPU write then read: cpuReq=1, cpuWR=1, cpuAddress=0x10, cpuData=0xDEADBEEF, next cycle cpuWR=0 -> memEn=1 in cycle 1; cpuValid=1 with cpuOut=0xDEADBEEF in cycle 3.
REQ-036 GPU stream only: gpuReq held high for 8 cycles, addresses 0..7 -> gpuGnt high every cycle; gpuValid high for 8 cycles starting one cycle later; gpuOut matches the RAM contents in order.
REQ-037 Starvation cap: cpuReq and gpuReq both held high, MAXHOLD=4 -> grant pattern CPU,CPU,CPU,CPU,GPU repeating; holdCnt returns to 0 after each GPU grant.
REQ-038 Contention with no read data: CPU writes to address 0x20 while gpuReq high for 3 cycles, MAXHOLD=4 -> CPU granted all 3 cycles; memEn=1 each cycle; gpuValid never high.
REQ-039 Reset mid-read: GPU grant in cycle t, rst=1 in cycle t+1 -> gpuValid=0 and gpuOut=0 in t+1; all outputs 0 during reset; normal grants resume after release.
REQ-040 Exclusivity: random cpuReq/gpuReq/cpuWR for 10000 cycles -> assertion that cpuGnt & gpuGnt is never 1; every valid follows a read grant by exactly 1 cycle.
